// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: result encoding and FSM states.
// Types and a width helper only; no logic.
package cmp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b10
    } cmp_result_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } cmp_state_t;

    // Digit index width; a single-digit build still needs a 1-bit index register.
    function automatic int idx_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// Operand/result handshake bundle for seq_magnitude_comparator.
// master = upstream producer and result consumer, slave = comparator.
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       result;
    logic [CW-1:0]    digits_used;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, digits_used
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, digits_used
    );

endinterface

// File: rtl/digit_compare.sv
// Combinational DIGIT-wide unsigned magnitude compare of x against y.
// Latency: none (pure combinational).
// Backpressure: not applicable.
module digit_compare
    import cmp_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output cmp_result_t      res
);

    always_comb begin
        res = CMP_EQ;
        if (x > y) begin
            res = CMP_GT;
        end else if (x < y) begin
            res = CMP_LT;
        end
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle A vs B magnitude compare, MSB digit first; CMP_SIGNED_EN selects two's complement.
// Latency: out_valid k edges after accept, k = digits examined (1..NDIG); k+2 cycle turnaround.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    seq_magnitude_comparator_if.slave   bus
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = idx_width(NDIG);
    localparam int CW   = $clog2(NDIG + 1);

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    cnt_q;
    cmp_result_t      res_q;
    logic             ov_q;

    logic [DIGIT-1:0] dig_x, dig_y;
    cmp_result_t      dig_res;
    logic             accept, retire, last, hit;

    always_comb begin
        dig_x = a_q[idx_q*DIGIT +: DIGIT];
        dig_y = b_q[idx_q*DIGIT +: DIGIT];
`ifdef CMP_SIGNED_EN
        // Flipping both sign bits maps two's complement order onto unsigned order.
        if (idx_q == IW'(NDIG - 1)) begin
            dig_x[DIGIT-1] = ~dig_x[DIGIT-1];
            dig_y[DIGIT-1] = ~dig_y[DIGIT-1];
        end
`endif
    end

    digit_compare #(.DIGIT(DIGIT)) u_digit_compare (
        .x   (dig_x),
        .y   (dig_y),
        .res (dig_res)
    );

    assign accept = bus.in_valid && bus.in_ready;
    assign retire = bus.out_valid && bus.out_ready;
    assign last   = (idx_q == '0);
    assign hit    = (dig_res != CMP_EQ);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last || ((EARLY_EXIT != 0) && hit)) state_d = DONE;
            DONE:    if (retire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            idx_q <= '0;
            cnt_q <= '0;
            res_q <= CMP_EQ;
            ov_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        idx_q <= IW'(NDIG - 1);
                        cnt_q <= '0;
                        res_q <= CMP_EQ;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    // Sticky: only the most significant differing digit decides.
                    if (res_q == CMP_EQ) res_q <= dig_res;
                    if (!last) idx_q <= idx_q - IW'(1);
                    if (state_d == DONE) ov_q <= 1'b1;
                end
                DONE: begin
                    if (retire) ov_q <= 1'b0;
                end
                default: ov_q <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = ov_q;
    assign bus.result      = res_q;
    assign bus.digits_used = cnt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench: three comparator builds (16/4 early exit, 16/4 full scan, 8/8) against a
// plain-arithmetic reference model.
module tb_seq_magnitude_comparator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int wd [3] = '{16, 16, 8};
    int dg [3] = '{4, 4, 8};
    int ee [3] = '{1, 0, 1};

    logic        vld  [3];
    logic        ordy [3];
    logic [15:0] opa  [3];
    logic [15:0] opb  [3];
    logic        ird  [3];
    logic        ov   [3];
    logic [1:0]  res  [3];
    logic [2:0]  dus  [3];

    seq_magnitude_comparator_if #(.WIDTH(16), .DIGIT(4)) i0 ();
    seq_magnitude_comparator_if #(.WIDTH(16), .DIGIT(4)) i1 ();
    seq_magnitude_comparator_if #(.WIDTH(8),  .DIGIT(8)) i2 ();

    assign i0.in_valid = vld[0];  assign i0.out_ready = ordy[0];
    assign i0.a = opa[0];         assign i0.b = opb[0];
    assign ird[0] = i0.in_ready;  assign ov[0] = i0.out_valid;
    assign res[0] = i0.result;    assign dus[0] = i0.digits_used;

    assign i1.in_valid = vld[1];  assign i1.out_ready = ordy[1];
    assign i1.a = opa[1];         assign i1.b = opb[1];
    assign ird[1] = i1.in_ready;  assign ov[1] = i1.out_valid;
    assign res[1] = i1.result;    assign dus[1] = i1.digits_used;

    assign i2.in_valid = vld[2];  assign i2.out_ready = ordy[2];
    assign i2.a = opa[2][7:0];    assign i2.b = opb[2][7:0];
    assign ird[2] = i2.in_ready;  assign ov[2] = i2.out_valid;
    assign res[2] = i2.result;    assign dus[2] = {2'b00, i2.digits_used};

    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(i0));
    seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(i1));
    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(8), .EARLY_EXIT(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(i2));

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: numeric compare of the operand values.
    function automatic logic [1:0] ref_res(input int d, input logic [15:0] a, input logic [15:0] b);
        longint va, vb;
        va = longint'(a);
        vb = longint'(b);
`ifdef CMP_SIGNED_EN
        if (a[wd[d]-1]) va = va - (longint'(1) << wd[d]);
        if (b[wd[d]-1]) vb = vb - (longint'(1) << wd[d]);
`endif
        if (va > vb) return 2'b01;
        if (va < vb) return 2'b10;
        return 2'b00;
    endfunction

    // Reference: digits from the MSB down to (and including) the highest differing bit.
    function automatic int ref_du(input int d, input logic [15:0] a, input logic [15:0] b);
        int ndig;
        logic [15:0] x;
        ndig = wd[d] / dg[d];
        x = a ^ b;
        if (ee[d] == 0 || x == 16'h0) return ndig;
        for (int p = wd[d] - 1; p >= 0; p--) begin
            if (x[p]) return ndig - p / dg[d];
        end
        return ndig;
    endfunction

    task automatic op(input int d, input logic [15:0] a, input logic [15:0] b,
                      input int hold, input string tag);
        int n, lat, edu;
        logic [1:0] er;
        er  = ref_res(d, a, b);
        edu = ref_du(d, a, b);
        opa[d] = a; opb[d] = b; vld[d] = 1'b1;
        n = 0;
        while (!ird[d] && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, "_accept"}, 32'(n < 50), 1);
        @(posedge clk); #1;
        vld[d] = 1'b0;
        opa[d] = 16'($urandom); opb[d] = 16'($urandom);
        lat = 0;
        while (!ov[d] && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({tag, "_latency"}, lat, edu);
        chk({tag, "_result"}, res[d], er);
        chk({tag, "_digits"}, dus[d], edu);
        for (int i = 0; i < hold; i++) begin
            vld[d] = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, ov[d], 1);
            chk({tag, "_hold_result"}, res[d], er);
            chk({tag, "_hold_digits"}, dus[d], edu);
            chk({tag, "_hold_ready"}, ird[d], 0);
        end
        vld[d] = 1'b0;
        ordy[d] = 1'b1;
        @(posedge clk); #1;
        ordy[d] = 1'b0;
        chk({tag, "_drop"}, ov[d], 0);
        chk({tag, "_idle"}, ird[d], 1);
    endtask

    task automatic new_ops(input int d);
        logic [15:0] mask;
        mask = (wd[d] == 16) ? 16'hFFFF : 16'h00FF;
        opa[d] = 16'($urandom) & mask;
        case ($urandom_range(0, 3))
            0:       opb[d] = opa[d];
            1:       opb[d] = opa[d] ^ (16'h1 << $urandom_range(0, wd[d] - 1));
            default: opb[d] = 16'($urandom) & mask;
        endcase
    endtask

    task automatic stream(input int d, input int nops);
        logic [31:0] q[$];
        logic [31:0] e;
        int sent, got, cyc, limit;
        logic acc, ret;
        sent = 0; got = 0; cyc = 0;
        limit = nops * (wd[d] / dg[d] + 4) + 100;
        new_ops(d);
        vld[d] = 1'b1; ordy[d] = 1'b1;
        while (got < nops && cyc < limit) begin
            acc = vld[d] && ird[d];
            ret = ov[d];
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                q.push_back({opa[d], opb[d]});
                sent++;
                if (sent == nops) vld[d] = 1'b0;
                else new_ops(d);
            end
            if (ret) begin
                got++;
                if (q.size() == 0) begin
                    chk($sformatf("s%0d_spurious", d), 1, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("s%0d_result", d), res[d], ref_res(d, e[31:16], e[15:0]));
                    chk($sformatf("s%0d_digits", d), dus[d], ref_du(d, e[31:16], e[15:0]));
                end
            end
        end
        vld[d] = 1'b0; ordy[d] = 1'b0;
        chk($sformatf("s%0d_count", d), got, nops);
        chk($sformatf("s%0d_sent", d), sent, nops);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            vld[d] = 1'b0; ordy[d] = 1'b0; opa[d] = '0; opb[d] = '0;
        end
        rst_n = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d_valid", d), ov[d], 0);
            chk($sformatf("rst%0d_result", d), res[d], 0);
            chk($sformatf("rst%0d_digits", d), dus[d], 0);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_ready", ird[0], 1);

        op(0, 16'h8000, 16'h7FFF, 0, "t1");
        op(0, 16'hA5A5, 16'hA5A5, 0, "t2");
        op(0, 16'h1234, 16'h1235, 0, "t3");
        op(1, 16'h2000, 16'h1FFF, 0, "t3_full");
        op(0, 16'h0F00, 16'h0F10, 5, "t4");

        // Reset during RUN.
        opa[0] = 16'h1234; opb[0] = 16'h1234; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", ov[0], 0);
        chk("t5_rst_result", res[0], 0);
        chk("t5_rst_digits", dus[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t5_ready", ird[0], 1);
        repeat (6) @(posedge clk);
        #1 chk("t5_no_valid", ov[0], 0);
        op(0, 16'hFFFF, 16'h0001, 0, "t5_next");

        op(2, 16'h0080, 16'h007F, 0, "t6_n1_gt");
        op(2, 16'h0033, 16'h0033, 0, "t6_n1_eq");
        op(1, 16'h0000, 16'h0001, 0, "t6_full_lt");

        stream(0, 1000);
        stream(1, 1000);
        stream(2, 1000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
